// File: rtl/audio_fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_fx_pkg
//  Description : Shared types and saturation helper for the echo engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_fx_pkg;

    typedef enum logic [1:0] {
        BYPASS  = 2'd0,
        FF_ECHO = 2'd1,
        FB_ECHO = 2'd2,
        MUTE    = 2'd3
    } fx_mode_e;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_LATCH = 3'd3,
        ST_MEM   = 3'd4,
        ST_CALC  = 3'd5,
        ST_WR    = 3'd6
    } fx_state_e;

    localparam int c_SAT_W = 32;

    // Clamp a sign-extended value into a signed range of 'width' bits.
    function automatic logic signed [c_SAT_W-1:0] saturate(
        input  logic signed [c_SAT_W-1:0] value,
        input  int                        width,
        output logic                      clipped
    );
        logic signed [c_SAT_W-1:0] w_hi;
        logic signed [c_SAT_W-1:0] w_lo;
        w_hi    = $signed((c_SAT_W'(1) << (width - 1)) - c_SAT_W'(1));
        w_lo    = ~w_hi;
        clipped = (value > w_hi) || (value < w_lo);
        if (value > w_hi)
            return w_hi;
        else if (value < w_lo)
            return w_lo;
        else
            return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_delay_ram.sv
`default_nettype none
// ============================================================================
//  Module      : echo_delay_ram
//  Description : Simple dual-port synchronous RAM, one-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            r_mem[waddr] <= wdata;
        rdata <= r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/audio_echo_engine.sv
`default_nettype none
// ============================================================================
//  Module      : audio_echo_engine
//  Description : Per-channel delay-line echo between the RX and TX audio FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_echo_engine
    import audio_fx_pkg::*;
#(
    parameter int CH_WIDTH    = 16,
    parameter int NUM_CH      = 2,
    parameter int DELAY_DEPTH = 4096,
    parameter int GAIN_WIDTH  = 6
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [1:0]                     mode,
    input  logic [$clog2(DELAY_DEPTH)-1:0] delay_len,
    input  logic [GAIN_WIDTH-1:0]          gain,
    input  logic                           adcfifo_empty,
    output logic                           adcfifo_read,
    input  logic [NUM_CH*CH_WIDTH-1:0]     adcfifo_readdata,
    input  logic                           dacfifo_full,
    output logic                           dacfifo_write,
    output logic [NUM_CH*CH_WIDTH-1:0]     dacfifo_writedata,
    output logic                           busy,
    output logic                           clip
);

    localparam int c_PTR_W      = $clog2(DELAY_DEPTH);
    localparam int c_CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_ADDR_W     = c_CH_W + c_PTR_W;
    localparam int c_WORD_W     = NUM_CH * CH_WIDTH;
    localparam int c_PROD_W     = CH_WIDTH + GAIN_WIDTH + 1;
    localparam int c_CLEAR_LAST = NUM_CH * DELAY_DEPTH - 1;

    fx_state_e             r_state;
    fx_mode_e              r_mode;
    logic [c_ADDR_W-1:0]   r_clr_addr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_delay;
    logic [GAIN_WIDTH-1:0] r_gain;
    logic [c_CH_W-1:0]     r_ch;
    logic [c_WORD_W-1:0]   r_in_word;
    logic [c_WORD_W-1:0]   r_out_word;
    logic                  r_clip;

    logic signed [CH_WIDTH-1:0] w_x;
    logic signed [CH_WIDTH-1:0] w_d;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [CH_WIDTH:0]   w_wet;
    logic signed [CH_WIDTH:0]   w_sum;
    logic [CH_WIDTH-1:0]        w_y_sat;
    logic [CH_WIDTH-1:0]        w_y;
    logic [CH_WIDTH-1:0]        w_ram_wdata;
    logic [CH_WIDTH-1:0]        w_ram_rdata;
    logic [c_ADDR_W-1:0]        w_waddr;
    logic [c_ADDR_W-1:0]        w_raddr;
    logic                       w_we;
    logic                       w_sat_hit;
    logic                       w_echo;
    logic                       w_frame_clip;

    // Datapath for the channel currently in CALC; the RAM word is valid here.
    always_comb begin
        w_x     = r_in_word[int'(r_ch)*CH_WIDTH +: CH_WIDTH];
        w_d     = w_ram_rdata;
        w_prod  = c_PROD_W'(w_d) * c_PROD_W'($signed({1'b0, r_gain}));
        w_wet   = (CH_WIDTH+1)'(w_prod >>> GAIN_WIDTH);
        w_sum   = {w_x[CH_WIDTH-1], w_x} + w_wet;
        w_y_sat = CH_WIDTH'(saturate(c_SAT_W'(w_sum), CH_WIDTH, w_sat_hit));
        w_echo  = ((r_mode == FF_ECHO) || (r_mode == FB_ECHO)) && (r_delay != '0);
        w_frame_clip = w_echo && w_sat_hit;
        case (r_mode)
            BYPASS:  w_y = w_x;
            MUTE:    w_y = '0;
            default: w_y = w_echo ? w_y_sat : w_x;
        endcase
        w_ram_wdata = ((r_mode == FB_ECHO) && w_echo) ? w_y : w_x;
        if (r_state == ST_CLEAR)
            w_ram_wdata = '0;
    end

    assign w_we    = (r_state == ST_CLEAR) || (r_state == ST_CALC);
    assign w_waddr = (r_state == ST_CLEAR) ? r_clr_addr : {r_ch, r_wr_ptr};
    assign w_raddr = {r_ch, r_wr_ptr - r_delay};

    echo_delay_ram #(
        .DATA_W (CH_WIDTH),
        .ADDR_W (c_ADDR_W)
    ) u_delay_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_ram_wdata),
        .raddr (w_raddr),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_CLEAR;
            r_mode     <= BYPASS;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
            r_delay    <= '0;
            r_gain     <= '0;
            r_ch       <= '0;
            r_in_word  <= '0;
            r_out_word <= '0;
            r_clip     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_addr == c_ADDR_W'(c_CLEAR_LAST)) begin
                        r_clr_addr <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + c_ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!adcfifo_empty)
                        r_state <= ST_RD;
                end
                ST_RD: r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_in_word <= adcfifo_readdata;
                    r_mode    <= fx_mode_e'(mode);
                    r_delay   <= delay_len;
                    r_gain    <= gain;
                    r_ch      <= '0;
                    r_clip    <= 1'b0;
                    r_state   <= ST_MEM;
                end
                ST_MEM: r_state <= ST_CALC;
                ST_CALC: begin
                    r_out_word[int'(r_ch)*CH_WIDTH +: CH_WIDTH] <= w_y;
                    r_clip <= r_clip | w_frame_clip;
                    if (r_ch == c_CH_W'(NUM_CH - 1)) begin
                        r_state <= ST_WR;
                    end else begin
                        r_ch    <= r_ch + c_CH_W'(1);
                        r_state <= ST_MEM;
                    end
                end
                ST_WR: begin
                    if (!dacfifo_full) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    // The push strobe follows full combinationally so a freed slot is used at once.
    assign adcfifo_read      = (r_state == ST_RD);
    assign dacfifo_write     = (r_state == ST_WR) && !dacfifo_full;
    assign dacfifo_writedata = r_out_word;
    assign busy              = (r_state == ST_CLEAR);
    assign clip              = dacfifo_write && r_clip;

endmodule
`default_nettype wire

// File: tb/tb_audio_echo_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_echo_engine
//  Description : Directed self-checking bench for audio_echo_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_echo_engine;

    localparam int CH_WIDTH    = 16;
    localparam int NUM_CH      = 2;
    localparam int DELAY_DEPTH = 16;
    localparam int GAIN_WIDTH  = 6;
    localparam int WORD_W      = NUM_CH * CH_WIDTH;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        mode;
    logic [3:0]        delay_len;
    logic [5:0]        gain;
    logic              adcfifo_empty;
    logic              adcfifo_read;
    logic [WORD_W-1:0] adcfifo_readdata;
    logic              dacfifo_full;
    logic              dacfifo_write;
    logic [WORD_W-1:0] dacfifo_writedata;
    logic              busy;
    logic              clip;

    int n_checks = 0;
    int n_errors = 0;

    audio_echo_engine #(
        .CH_WIDTH    (CH_WIDTH),
        .NUM_CH      (NUM_CH),
        .DELAY_DEPTH (DELAY_DEPTH),
        .GAIN_WIDTH  (GAIN_WIDTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mode              (mode),
        .delay_len         (delay_len),
        .gain              (gain),
        .adcfifo_empty     (adcfifo_empty),
        .adcfifo_read      (adcfifo_read),
        .adcfifo_readdata  (adcfifo_readdata),
        .dacfifo_full      (dacfifo_full),
        .dacfifo_write     (dacfifo_write),
        .dacfifo_writedata (dacfifo_writedata),
        .busy              (busy),
        .clip              (clip)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offers one word to the engine and collects the resulting push.
    task automatic do_frame(input logic [WORD_W-1:0] word, output logic [WORD_W-1:0] out,
                            output int clips, output int reads, output bit done);
        done  = 1'b0;
        clips = 0;
        reads = 0;
        out   = '0;
        adcfifo_empty = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (adcfifo_read) begin
                reads++;
                adcfifo_empty    = 1'b1;
                adcfifo_readdata = word;
            end
            if (clip)
                clips++;
            if (dacfifo_write) begin
                out  = dacfifo_writedata;
                done = 1'b1;
                break;
            end
        end
        adcfifo_empty = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        adcfifo_empty = 1'b1;
        dacfifo_full  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!busy)
                break;
            @(negedge clk);
        end
        if (busy) begin
            n_errors++;
            $display("FAIL reset_clear_timeout: busy still %b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        int cnt;
        reset_n = 1'b0;
        adcfifo_empty = 1'b1;
        dacfifo_full = 1'b0;
        adcfifo_readdata = '0;
        mode = 2'd0;
        delay_len = '0;
        gain = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (adcfifo_read !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %b exp 0", adcfifo_read); end
        n_checks++;
        if (dacfifo_write !== 1'b0) begin n_errors++; $display("FAIL reset_write: got %b exp 0", dacfifo_write); end
        n_checks++;
        if (dacfifo_writedata !== 32'h0) begin n_errors++; $display("FAIL reset_wdata: got %h exp 0", dacfifo_writedata); end
        n_checks++;
        if (clip !== 1'b0) begin n_errors++; $display("FAIL reset_clip: got %b exp 0", clip); end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b exp 1", busy); end
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1)
                break;
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 32) begin n_errors++; $display("FAIL reset_busy_len: got %0d cycles exp 32", cnt); end
    endtask

    task automatic test_bypass();
        logic [WORD_W-1:0] vin [2];
        logic [WORD_W-1:0] out;
        int clips, reads;
        bit done;
        vin[0] = 32'h1234_8001;
        vin[1] = 32'h7FFF_8000;
        apply_reset();
        mode = 2'd0; delay_len = 4'd1; gain = 6'd63;
        for (int f = 0; f < 2; f++) begin
            do_frame(vin[f], out, clips, reads, done);
            n_checks++;
            if (!done || out !== vin[f]) begin
                n_errors++; $display("FAIL bypass_data f%0d: got %h exp %h done=%0d", f, out, vin[f], done);
            end
            n_checks++;
            if (clips != 0) begin n_errors++; $display("FAIL bypass_clip f%0d: got %0d exp 0", f, clips); end
            n_checks++;
            if (reads != 1) begin n_errors++; $display("FAIL bypass_pops f%0d: got %0d exp 1", f, reads); end
        end
    endtask

    task automatic test_ff_impulse();
        logic [WORD_W-1:0] out, exp_v;
        int clips, reads;
        bit done;
        apply_reset();
        mode = 2'd1; delay_len = 4'd4; gain = 6'd32;
        for (int f = 0; f < 9; f++) begin
            do_frame((f == 0) ? 32'h0000_4000 : 32'h0, out, clips, reads, done);
            exp_v = (f == 0) ? 32'h0000_4000 : (f == 4) ? 32'h0000_2000 : 32'h0;
            n_checks++;
            if (!done || out !== exp_v) begin
                n_errors++; $display("FAIL ff_impulse f%0d: got %h exp %h done=%0d", f, out, exp_v, done);
            end
        end
    endtask

    task automatic test_fb_decay();
        logic [WORD_W-1:0] out, exp_v;
        int clips, reads;
        bit done;
        apply_reset();
        mode = 2'd2; delay_len = 4'd3; gain = 6'd32;
        for (int f = 0; f < 10; f++) begin
            do_frame((f == 0) ? 32'h0000_4000 : 32'h0, out, clips, reads, done);
            case (f)
                0: exp_v = 32'h0000_4000;
                3: exp_v = 32'h0000_2000;
                6: exp_v = 32'h0000_1000;
                9: exp_v = 32'h0000_0800;
                default: exp_v = 32'h0;
            endcase
            n_checks++;
            if (!done || out !== exp_v) begin
                n_errors++; $display("FAIL fb_decay f%0d: got %h exp %h done=%0d", f, out, exp_v, done);
            end
        end
    endtask

    task automatic test_saturation();
        logic [WORD_W-1:0] vin [4];
        logic [WORD_W-1:0] vexp [4];
        int cexp [4];
        logic [WORD_W-1:0] out;
        int clips, reads;
        bit done;
        vin[0] = 32'h0000_7FFF; vexp[0] = 32'h0000_7FFF; cexp[0] = 0;
        vin[1] = 32'h0000_7FFF; vexp[1] = 32'h0000_7FFF; cexp[1] = 1;
        vin[2] = 32'h0000_8000; vexp[2] = 32'h0000_FDFF; cexp[2] = 0;
        vin[3] = 32'h0000_8000; vexp[3] = 32'h0000_8000; cexp[3] = 1;
        apply_reset();
        mode = 2'd1; delay_len = 4'd1; gain = 6'd63;
        for (int f = 0; f < 4; f++) begin
            do_frame(vin[f], out, clips, reads, done);
            n_checks++;
            if (!done || out !== vexp[f]) begin
                n_errors++; $display("FAIL sat_data f%0d: got %h exp %h done=%0d", f, out, vexp[f], done);
            end
            n_checks++;
            if (clips != cexp[f]) begin
                n_errors++; $display("FAIL sat_clip f%0d: got %0d pulses exp %0d", f, clips, cexp[f]);
            end
        end
    endtask

    task automatic test_mute_and_mode_change();
        logic [WORD_W-1:0] out;
        int clips, reads;
        bit done;
        apply_reset();
        mode = 2'd3; delay_len = 4'd1; gain = 6'd32;
        do_frame(32'h0000_4000, out, clips, reads, done);
        n_checks++;
        if (!done || out !== 32'h0) begin n_errors++; $display("FAIL mute_out: got %h exp 0", out); end
        mode = 2'd1;
        do_frame(32'h0, out, clips, reads, done);
        n_checks++;
        if (!done || out !== 32'h0000_2000) begin n_errors++; $display("FAIL mute_history: got %h exp 00002000", out); end
        mode = 2'd2; delay_len = 4'd0; gain = 6'd63;
        do_frame(32'h0000_7FFF, out, clips, reads, done);
        n_checks++;
        if (!done || out !== 32'h0000_7FFF) begin n_errors++; $display("FAIL dry_delay0: got %h exp 00007fff", out); end
        n_checks++;
        if (clips != 0) begin n_errors++; $display("FAIL dry_delay0_clip: got %0d exp 0", clips); end
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] word;
        bit seen;
        word = 32'hABCD_1357;
        apply_reset();
        mode = 2'd0;
        dacfifo_full  = 1'b1;
        adcfifo_empty = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adcfifo_read) begin
                seen = 1'b1;
                adcfifo_empty    = 1'b1;
                adcfifo_readdata = word;
                break;
            end
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL bp_pop: got no pop exp 1"); end
        repeat (10) @(negedge clk);
        adcfifo_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (dacfifo_write !== 1'b0) begin n_errors++; $display("FAIL bp_write c%0d: got %b exp 0", i, dacfifo_write); end
            n_checks++;
            if (dacfifo_writedata !== word) begin n_errors++; $display("FAIL bp_hold c%0d: got %h exp %h", i, dacfifo_writedata, word); end
            n_checks++;
            if (adcfifo_read !== 1'b0) begin n_errors++; $display("FAIL bp_nopop c%0d: got %b exp 0", i, adcfifo_read); end
        end
        @(negedge clk);
        dacfifo_full  = 1'b0;
        adcfifo_empty = 1'b1;
        #1;
        n_checks++;
        if (dacfifo_write !== 1'b1) begin n_errors++; $display("FAIL bp_release: got %b exp 1", dacfifo_write); end
        n_checks++;
        if (dacfifo_writedata !== word) begin n_errors++; $display("FAIL bp_release_data: got %h exp %h", dacfifo_writedata, word); end
        @(negedge clk);
        n_checks++;
        if (dacfifo_write !== 1'b0) begin n_errors++; $display("FAIL bp_single_push: got %b exp 0", dacfifo_write); end
    endtask

    task automatic test_reset_mid_frame();
        logic [WORD_W-1:0] out, exp_v;
        int clips, reads, cnt;
        bit done;
        apply_reset();
        mode = 2'd0; delay_len = 4'd5; gain = 6'd32;
        for (int f = 0; f < 16; f++)
            do_frame(32'h0100_0100, out, clips, reads, done);
        mode = 2'd1;
        adcfifo_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adcfifo_read) begin
                adcfifo_empty    = 1'b1;
                adcfifo_readdata = 32'h0100_0100;
                break;
            end
        end
        adcfifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dacfifo_writedata !== 32'h0) begin n_errors++; $display("FAIL midrst_wdata: got %h exp 0", dacfifo_writedata); end
        n_checks++;
        if (dacfifo_write !== 1'b0 || adcfifo_read !== 1'b0 || clip !== 1'b0) begin
            n_errors++; $display("FAIL midrst_strobes: got w=%b r=%b c=%b exp 0", dacfifo_write, adcfifo_read, clip);
        end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy: got %b exp 1", busy); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1)
                break;
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 32) begin n_errors++; $display("FAIL midrst_busy_len: got %0d cycles exp 32", cnt); end
        for (int f = 0; f < 6; f++) begin
            do_frame(32'h0000_0100, out, clips, reads, done);
            exp_v = (f < 5) ? 32'h0000_0100 : 32'h0000_0180;
            n_checks++;
            if (!done || out !== exp_v) begin
                n_errors++; $display("FAIL midrst_run f%0d: got %h exp %h done=%0d", f, out, exp_v, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_ff_impulse();
        test_fb_decay();
        test_saturation();
        test_mute_and_mode_change();
        test_backpressure();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
